// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - unified memory handshake between controller and memory
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing a multicycle RISC-V style datapath
module multicycle_controller #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                opcode,
    input  logic [2:0]                funct3,
    input  logic                      zero,
    multicycle_controller_if.master   mem,
    output logic                      ir_write,
    output logic                      pc_write,
    output logic [1:0]                alu_src_a,
    output logic [1:0]                alu_src_b,
    output logic [1:0]                alu_op,
    output logic                      reg_write,
    output logic [1:0]                result_src,
    output logic                      fault,
    output logic [3:0]                state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_FAULT    = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [7:0] WAIT_MAX  = 8'(MEM_WAIT_MAX);

    state_t     cur_state;
    state_t     nxt_state;
    logic [7:0] wait_cnt;
    logic       wait_state;
    logic       wait_expired;
    logic       branch_taken;

    assign wait_state   = (cur_state == S_FETCH) || (cur_state == S_MEM_RD) || (cur_state == S_MEM_WR);
    assign wait_expired = wait_state && !mem.mem_ready && (wait_cnt == WAIT_MAX);
    assign branch_taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
    assign state        = cur_state;

    // The wait counter only ever counts while parked in one memory state,
    // so any state change resets it for the next access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= S_FETCH;
            wait_cnt  <= 8'd0;
        end else begin
            cur_state <= nxt_state;
            if (nxt_state != cur_state) begin
                wait_cnt <= 8'd0;
            end else if (wait_state && !mem.mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_FETCH: begin
                if (mem.mem_ready)      nxt_state = S_DECODE;
                else if (wait_expired)  nxt_state = S_FAULT;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: nxt_state = S_MEM_ADDR;
                    OP_RTYPE:          nxt_state = S_EXEC_R;
                    OP_ITYPE:          nxt_state = S_EXEC_I;
                    OP_BRANCH:         nxt_state = S_BRANCH;
                    OP_JAL:            nxt_state = S_JAL;
                    default:           nxt_state = S_FAULT;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LOAD)       nxt_state = S_MEM_RD;
                else if (opcode == OP_STORE) nxt_state = S_MEM_WR;
                else                         nxt_state = S_FAULT;
            end
            S_MEM_RD: begin
                if (mem.mem_ready)      nxt_state = S_MEM_WB;
                else if (wait_expired)  nxt_state = S_FAULT;
            end
            S_MEM_WR: begin
                if (mem.mem_ready)      nxt_state = S_FETCH;
                else if (wait_expired)  nxt_state = S_FAULT;
            end
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL: nxt_state = S_FETCH;
            S_EXEC_R, S_EXEC_I:                 nxt_state = S_ALU_WB;
            S_FAULT:                            nxt_state = S_FAULT;
            default:                            nxt_state = S_FAULT;
        endcase
    end

    always_comb begin
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        reg_write    = 1'b0;
        result_src   = 2'b00;
        fault        = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                // Gated so a ready seen while reset is held cannot load IR/PC.
                ir_write    = mem.mem_ready && !reset;
                pc_write    = mem.mem_ready && !reset;
                alu_src_b   = 2'b01;
            end
            S_DECODE: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem.mem_req  = 1'b1;
                mem.addr_sel = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
            end
            S_MEM_WR: begin
                mem.mem_req  = 1'b1;
                mem.mem_we   = 1'b1;
                mem.addr_sel = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b01;
                pc_write  = branch_taken;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                result_src = 2'b10;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                fault = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

    localparam int MAX = 3;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] ILL = 7'b1110011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       zero = 1'b0;
    logic       ir_write, pc_write, reg_write, fault;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [3:0] state;
    logic [14:0] got_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    multicycle_controller_if mem_if ();

    multicycle_controller #(.MEM_WAIT_MAX(MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .mem        (mem_if),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .result_src (result_src),
        .fault      (fault),
        .state      (state)
    );

    always #5 clk = ~clk;

    assign got_out = {mem_if.mem_req, mem_if.mem_we, mem_if.addr_sel, ir_write, pc_write,
                      alu_src_a, alu_src_b, alu_op, reg_write, result_src, fault};

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Output table per state, straight from the state descriptions.
    function automatic logic [14:0] exp_out(int st, logic rdy, logic z, logic [2:0] f3);
        logic req = 0, we = 0, as = 0, ir = 0, pc = 0, rw = 0, flt = 0;
        logic [1:0] a = 0, b = 0, op = 0, rs = 0;
        case (st)
            0:  begin req = 1; ir = rdy; pc = rdy; b = 2'b01; end
            1:  begin a = 2'b10; b = 2'b10; end
            2:  begin a = 2'b01; b = 2'b10; end
            3:  begin req = 1; as = 1; end
            4:  begin rw = 1; rs = 2'b01; end
            5:  begin req = 1; we = 1; as = 1; end
            6:  begin a = 2'b01; op = 2'b10; end
            7:  begin a = 2'b01; b = 2'b10; op = 2'b10; end
            8:  begin rw = 1; end
            9:  begin a = 2'b01; op = 2'b01;
                      pc = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0; end
            10: begin pc = 1; rw = 1; rs = 2'b10; end
            default: flt = 1;
        endcase
        return {req, we, as, ir, pc, a, b, op, rw, rs, flt};
    endfunction

    // One clock cycle: drive at the falling edge, check, move to next falling edge.
    task automatic step(int st, logic rdy, string tag);
        mem_if.mem_ready = rdy;
        #1;
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_out"}, 32'(got_out), 32'(exp_out(st, rdy, zero, funct3)));
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_if.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // An access with w idle cycles before ready; beyond MAX the controller must give up.
    task automatic mem_phase(int st, int w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= MAX; i++) begin
            if (i == w) begin
                step(st, 1'b1, "mem");
                ok = 1'b1;
                return;
            end
            step(st, 1'b0, "wait");
        end
    endtask

    task automatic fault_tail();
        repeat (3) step(15, rbit(), "fault");
        do_reset();
    endtask

    task automatic run_instr(logic [6:0] op, logic [2:0] f3, logic z, int fw, int mw);
        bit ok;
        opcode = op;
        funct3 = f3;
        zero   = z;
        mem_phase(0, fw, ok);
        if (!ok) begin fault_tail(); return; end
        step(1, rbit(), "decode");
        case (op)
            LD: begin
                step(2, rbit(), "maddr");
                mem_phase(3, mw, ok);
                if (!ok) begin fault_tail(); return; end
                step(4, rbit(), "memwb");
            end
            ST: begin
                step(2, rbit(), "maddr");
                mem_phase(5, mw, ok);
                if (!ok) begin fault_tail(); return; end
            end
            RT: begin step(6, rbit(), "execr"); step(8, rbit(), "aluwb"); end
            IT: begin step(7, rbit(), "execi"); step(8, rbit(), "aluwb"); end
            BR: step(9, rbit(), "branch");
            JL: step(10, rbit(), "jal");
            default: fault_tail();
        endcase
    endtask

    task automatic latency(string tag, logic [6:0] op, logic [2:0] f3, logic z, int mw, int cycles);
        int c0;
        c0 = cyc;
        run_instr(op, f3, z, 0, mw);
        check(tag, 32'(cyc - c0), 32'(cycles));
    endtask

    initial begin
        logic [6:0] ops [7];
        logic [2:0] f3s [4];
        logic [6:0] op;
        int fw, mw;
        ops = '{LD, ST, RT, IT, BR, JL, ILL};
        f3s = '{3'b000, 3'b001, 3'b100, 3'b000};

        mem_if.mem_ready = 1'b0;
        @(negedge clk);
        do_reset();

        latency("lat_rtype", RT, 3'b000, 1'b0, 0, 4);
        latency("lat_itype", IT, 3'b000, 1'b0, 0, 4);
        latency("lat_load",  LD, 3'b000, 1'b0, 0, 5);
        latency("lat_store", ST, 3'b000, 1'b0, 0, 4);
        latency("lat_jal",   JL, 3'b000, 1'b0, 0, 3);
        latency("lat_load_w3", LD, 3'b000, 1'b0, 3, 8);
        latency("lat_beq_z1", BR, 3'b000, 1'b1, 0, 3);
        latency("lat_bne_z1", BR, 3'b001, 1'b1, 0, 3);
        latency("lat_b100",   BR, 3'b100, 1'b1, 0, 3);
        latency("lat_bne_z0", BR, 3'b001, 1'b0, 0, 3);

        run_instr(RT, 3'b000, 1'b0, MAX, 0);
        check("ready_at_max_no_fault", 32'(fault), 32'd0);
        run_instr(RT, 3'b000, 1'b0, MAX + 1, 0);
        run_instr(LD, 3'b000, 1'b0, 0, MAX + 1);
        run_instr(ILL, 3'b000, 1'b0, 0, 0);

        // Asynchronous reset in the middle of a store access.
        opcode = ST; funct3 = 3'b000; zero = 1'b0;
        step(0, 1'b1, "st_fetch");
        step(1, 1'b0, "st_decode");
        step(2, 1'b0, "st_maddr");
        step(5, 1'b0, "st_wr");
        #2 reset = 1'b1;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_we", 32'(mem_if.mem_we), 32'd0);
        check("async_rst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(0, 1'b0, "post_rst_fetch");
        step(0, 1'b1, "post_rst_fetch2");
        step(1, 1'b0, "post_rst_decode");
        step(2, 1'b0, "post_rst_maddr");
        step(5, 1'b1, "post_rst_wr");

        for (int n = 0; n < 80; n++) begin
            op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 15) == 0) op = 7'($urandom);
            fw = ($urandom_range(0, 9) == 0) ? MAX + 1 : $urandom_range(0, MAX);
            mw = ($urandom_range(0, 9) == 0) ? MAX + 1 : $urandom_range(0, MAX);
            run_instr(op, f3s[$urandom_range(0, 3)] | 3'($urandom_range(0, 1) * $urandom_range(0, 7)),
                      rbit(), fw, mw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: MEM_WAIT_MAX, 15, max consecutive cycles mem_req may stay high without mem_ready before fault (range 1..255).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  7  opcode field of the latched instruction.
REQ-005 funct3  input  3  funct3 field of the latched instruction.
REQ-006 zero  input  1  ALU zero flag, combinational from current ALU operands.
REQ-007 mem_ready  input  1  unified memory completes the current access this cycle.
REQ-008 mem_req  output  1  memory access request.
REQ-009 mem_we  output  1  write strobe; valid only with mem_req.
REQ-010 addr_sel  output  1  memory address: 0 = PC, 1 = ALU result register.
REQ-011 ir_write  output  1  load instruction register.
REQ-012 pc_write  output  1  load PC from ALU result.
REQ-013 alu_src_a  output  2  00 PC, 01 read_data1, 10 old PC.
REQ-014 alu_src_b  output  2  00 read_data2, 01 constant 4, 10 immediate.
REQ-015 alu_op  output  2  00 add, 01 subtract/compare, 10 decode by funct3/funct7.
REQ-016 reg_write  output  1  register file write enable.
REQ-017 result_src  output  2  write-back source: 00 ALU result, 01 memory data, 10 PC+4.
REQ-018 fault  output  1  sticky error flag.
REQ-019 state  output  4  current state encoding (debug).

Function
REQ-020 Moore FSM; states/encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JAL 10, FAULT 15; all outputs decoded from state (plus mem_ready/zero where noted); unlisted outputs 0.
REQ-021 FETCH: mem_req=1, addr_sel=0, alu_src_a=00, alu_src_b=01, alu_op=00; on mem_ready=1 assert ir_write=1, pc_write=1 same cycle, go DECODE; else stay.
REQ-022 DECODE (1 cycle): alu_src_a=10, alu_src_b=10, alu_op=00 (branch target precompute); next state by opcode: 0000011/0100011 -> MEM_ADDR, 0110011 -> EXEC_R, 0010011 -> EXEC_I, 1100011 -> BRANCH, 1101111 -> JAL, any other -> FAULT.
REQ-023 MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00; opcode 0000011 -> MEM_RD, 0100011 -> MEM_WR.
REQ-024 MEM_RD: mem_req=1, addr_sel=1, mem_we=0; mem_ready -> MEM_WB.
REQ-025 MEM_WB: reg_write=1, result_src=01 -> FETCH.
REQ-026 MEM_WR: mem_req=1, mem_we=1, addr_sel=1; mem_ready -> FETCH.
REQ-027 EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10 -> ALU_WB; EXEC_I: alu_src_a=01, alu_src_b=10, alu_op=10 -> ALU_WB.
REQ-028 ALU_WB: reg_write=1, result_src=00 -> FETCH.
REQ-029 BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01; pc_write = (funct3==000 & zero) | (funct3==001 & ~zero); other funct3 never taken; -> FETCH.
REQ-030 JAL: pc_write=1 (target from DECODE), reg_write=1, result_src=10 -> FETCH.
REQ-031 Handshake: mem_req, mem_we, addr_sel held stable until the cycle mem_ready=1; access completes in that cycle; mem_ready outside memory states ignored.
REQ-032 Wait counter: 8-bit, cleared on every state transition, increments each cycle in FETCH/MEM_RD/MEM_WR with mem_ready=0; when counter reaches MEM_WAIT_MAX with mem_ready still 0, next state FAULT; mem_ready=1 on that same cycle wins (normal completion).
REQ-033 FAULT: all strobes 0, fault=1; absorbing, exit only by reset.
REQ-034 Latency: R/I-type 4 cycles, load 5, store 4, branch/jal 3 (zero-wait memory).

Reset
REQ-035 reset=1 forces state=FETCH, wait counter=0, fault=0 immediately, independent of clk; mid-access requests are abandoned, no write strobes asserted during reset.
REQ-036 After reset deassertion, first rising edge evaluates FETCH with mem_req=1.

Verification
REQ-037 Zero-wait add (opcode 0110011), mem_ready tied 1 -> states 0,1,6,8,0; reg_write high exactly 1 cycle in state 8.
REQ-038 Load with mem_ready low 3 cycles in MEM_RD -> mem_req/addr_sel=1 held 4 cycles, MEM_WB after, total 8 cycles.
REQ-039 BEQ zero=1 -> pc_write high in BRANCH; BNE zero=1 -> pc_write low; funct3=100 -> never taken.
REQ-040 mem_ready held 0 in FETCH, MEM_WAIT_MAX=3 -> FAULT entered after 3 wait cycles, fault=1 sticky; mem_ready=1 on counter==3 -> DECODE, no fault.
REQ-041 Opcode 1110011 in DECODE -> FAULT; reset pulse mid MEM_WR (async, between edges) -> state=0, mem_we=0 immediately.
